dual_beam_trigger_scaler: RTL and testbench

- Sits directly downstream of the dual-beam threshold stage and consumes its per-beam trigger bits.
- Per beam, it applies a retrigger holdoff and masking, then emits a clean one-cycle trigger pulse.
- Per beam, it counts accepted triggers over a fixed gate period with saturating scalers and latches the counts at each period end for rate monitoring and threshold servoing.

---
 rtl/dual_beam_trigger_scaler.sv | 154 +++++++++++++++
 tb/tb_dual_beam_trigger_scaler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dual_beam_trigger_scaler.sv
// Per-beam trigger holdoff/masking with one-cycle pulses and gated saturating rate scalers.
// Optional BEAM_SCALER_OVERFLOW_EN adds overflow_o, a per-beam "saturated and still counting" flag.
module dual_beam_trigger_scaler #(
    parameter int NBEAMS   = 2,
    parameter int HOLDOFF  = 16,
    parameter int PERIOD   = 375000,
    parameter int CNT_BITS = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NBEAMS-1:0]            trigger_i,
    input  logic [NBEAMS-1:0]            mask_i,
    output logic [NBEAMS-1:0]            trig_o,
    output logic                         trig_any_o,
    output logic [NBEAMS*CNT_BITS-1:0]   count_o,
    output logic                         count_valid_o
`ifdef BEAM_SCALER_OVERFLOW_EN
    ,
    output logic [NBEAMS-1:0]            overflow_o
`endif
);

    localparam int HW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int PW = $clog2(PERIOD);
    localparam logic [HW-1:0]       HOLDOFF_LOAD = HW'(HOLDOFF);
    localparam logic [PW-1:0]       PERIOD_LAST  = PW'(PERIOD - 1);
    localparam logic [CNT_BITS-1:0] CNT_MAX      = '1;

    logic [NBEAMS-1:0]                trig_s1_r;
    logic [NBEAMS-1:0]                mask_s1_r;
    logic [NBEAMS-1:0][HW-1:0]        holdoff_r;
    logic [NBEAMS-1:0][HW-1:0]        holdoff_nxt_s;
    logic [NBEAMS-1:0][CNT_BITS-1:0]  acc_r;
    logic [NBEAMS-1:0][CNT_BITS-1:0]  acc_nxt_s;
    logic [NBEAMS-1:0][CNT_BITS-1:0]  close_s;
    logic [NBEAMS-1:0]                accept_s;
    logic [PW-1:0]                    period_r;
    logic [PW-1:0]                    period_nxt_s;
    logic                             period_end_s;

    function automatic logic [CNT_BITS-1:0] sat_inc(
        input logic [CNT_BITS-1:0] value,
        input logic                inc
    );
        logic [CNT_BITS-1:0] result;
        if (inc && (value != CNT_MAX)) begin
            result = value + CNT_BITS'(1);
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Gate period counter; the last cycle closes the scaler window.
    always_comb begin
        period_end_s = (period_r == PERIOD_LAST);
        if (period_end_s) begin
            period_nxt_s = '0;
        end else begin
            period_nxt_s = period_r + PW'(1);
        end
    end

    // Per-beam acceptance, holdoff next-state and scaler next-state.
    always_comb begin
        accept_s      = '0;
        holdoff_nxt_s = '0;
        close_s       = '0;
        acc_nxt_s     = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            accept_s[b] = trig_s1_r[b] & ~mask_s1_r[b] & (holdoff_r[b] == '0);
            if (accept_s[b]) begin
                holdoff_nxt_s[b] = HOLDOFF_LOAD;
            end else if (holdoff_r[b] != '0) begin
                holdoff_nxt_s[b] = holdoff_r[b] - HW'(1);
            end else begin
                holdoff_nxt_s[b] = '0;
            end
            // An accept on the closing cycle still belongs to the closing window.
            close_s[b] = sat_inc(acc_r[b], accept_s[b]);
            if (period_end_s) begin
                acc_nxt_s[b] = '0;
            end else begin
                acc_nxt_s[b] = close_s[b];
            end
        end
    end

    // Input stage, holdoff counters, accumulators and period counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_s1_r <= '0;
            mask_s1_r <= '0;
            holdoff_r <= '0;
            acc_r     <= '0;
            period_r  <= '0;
        end else begin
            trig_s1_r <= trigger_i;
            mask_s1_r <= mask_i;
            holdoff_r <= holdoff_nxt_s;
            acc_r     <= acc_nxt_s;
            period_r  <= period_nxt_s;
        end
    end

    // Registered trigger pulses and latched scaler outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            trig_o        <= '0;
            trig_any_o    <= 1'b0;
            count_o       <= '0;
            count_valid_o <= 1'b0;
        end else begin
            trig_o        <= accept_s;
            trig_any_o    <= |accept_s;
            count_valid_o <= period_end_s;
            if (period_end_s) begin
                for (int b = 0; b < NBEAMS; b++) begin
                    count_o[b*CNT_BITS +: CNT_BITS] <= close_s[b];
                end
            end else begin
                count_o <= count_o;
            end
        end
    end

`ifdef BEAM_SCALER_OVERFLOW_EN
    logic [NBEAMS-1:0] ovf_acc_r;
    logic [NBEAMS-1:0] ovf_close_s;

    // Overflow is an accept that arrives while the accumulator is already full.
    always_comb begin
        ovf_close_s = '0;
        for (int b = 0; b < NBEAMS; b++) begin
            ovf_close_s[b] = ovf_acc_r[b] | (accept_s[b] & (acc_r[b] == CNT_MAX));
        end
    end

    // Per-window overflow tracking, latched alongside count_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_acc_r  <= '0;
            overflow_o <= '0;
        end else if (period_end_s) begin
            ovf_acc_r  <= '0;
            overflow_o <= ovf_close_s;
        end else begin
            ovf_acc_r  <= ovf_close_s;
            overflow_o <= overflow_o;
        end
    end
`endif

endmodule

// File: tb/tb_dual_beam_trigger_scaler.sv
// Directed bench for dual_beam_trigger_scaler with HOLDOFF=4, PERIOD=100, CNT_BITS=4.
module tb_dual_beam_trigger_scaler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] trigger = 2'b00;
    logic [1:0] mask = 2'b00;
    logic [1:0] trig;
    logic       trig_any;
    logic [7:0] count;
    logic       count_valid;
`ifdef BEAM_SCALER_OVERFLOW_EN
    logic [1:0] overflow;
`endif

    int checks = 0;
    int errors = 0;
    int ph = 0;
    int cv_seen = 0;
    int last_cv_ph = -1;
    int any_bad = 0;
    int pulse_cnt[2];

    typedef struct {
        logic [1:0] trig;
        logic [1:0] mask;
        logic [1:0] exp_trig;
        logic       exp_any;
    } vec_t;

    vec_t vecs[37];

    always #5 clk = ~clk;

    dual_beam_trigger_scaler #(
        .NBEAMS(2),
        .HOLDOFF(4),
        .PERIOD(100),
        .CNT_BITS(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .trigger_i(trigger),
        .mask_i(mask),
        .trig_o(trig),
        .trig_any_o(trig_any),
        .count_o(count),
        .count_valid_o(count_valid)
`ifdef BEAM_SCALER_OVERFLOW_EN
        ,
        .overflow_o(overflow)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ph counts edges since the last reset edge; the S1 sample of a step's input
    // is evaluated while the period counter equals ph mod 100.
    task automatic step(input logic r, input logic [1:0] t, input logic [1:0] m);
        rst = r;
        trigger = t;
        mask = m;
        @(posedge clk);
        #1;
        if (r) ph = 0;
        else ph++;
        for (int b = 0; b < 2; b++) begin
            if (trig[b] === 1'b1) pulse_cnt[b]++;
        end
        if (trig_any !== (|trig)) any_bad++;
        if (count_valid === 1'b1) begin
            cv_seen++;
            last_cv_ph = ph;
        end
    endtask

    task automatic run_to(input int target, input logic [1:0] t, input logic [1:0] m);
        while (ph < target) step(1'b0, t, m);
    endtask

    task automatic check_strobe(input string name, input int exp_ph, input logic [7:0] exp_count);
        check({name, "_cv_ph"}, last_cv_ph, exp_ph);
        check({name, "_cv_num"}, cv_seen, 1);
        check({name, "_cv_now"}, 32'(count_valid), 32'd1);
        check({name, "_count"}, 32'(count), 32'(exp_count));
        cv_seen = 0;
    endtask

    task automatic apply_vecs(input int first, input int last, input string name);
        for (int i = first; i <= last; i++) begin
            step(1'b0, vecs[i].trig, vecs[i].mask);
            check($sformatf("%s%0d_trig", name, i - first), 32'(trig), 32'(vecs[i].exp_trig));
            check($sformatf("%s%0d_any", name, i - first), 32'(trig_any), 32'(vecs[i].exp_any));
        end
    endtask

    initial begin
        // Holdoff: beam 0 high for 20 steps, pulses on steps 2, 7, 12, 17.
        for (int i = 0; i < 25; i++) begin
            vecs[i].trig     = (i < 20) ? 2'b01 : 2'b00;
            vecs[i].mask     = 2'b00;
            vecs[i].exp_trig = (i == 1 || i == 6 || i == 11 || i == 16) ? 2'b01 : 2'b00;
            vecs[i].exp_any  = (i == 1 || i == 6 || i == 11 || i == 16) ? 1'b1 : 1'b0;
        end
        // Mask: masked for 5 steps, then unmasked; single pulse 2 cycles after mask falls.
        for (int j = 0; j < 12; j++) begin
            vecs[25 + j].trig     = (j < 10) ? 2'b01 : 2'b00;
            vecs[25 + j].mask     = (j < 5) ? 2'b01 : 2'b00;
            vecs[25 + j].exp_trig = (j == 6) ? 2'b01 : 2'b00;
            vecs[25 + j].exp_any  = (j == 6) ? 1'b1 : 1'b0;
        end
        pulse_cnt = '{0, 0};

        repeat (5) step(1'b1, 2'b11, 2'b00);
        check("rst_trig", 32'(trig), 32'd0);
        check("rst_any", 32'(trig_any), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_cv", 32'(count_valid), 32'd0);
`ifdef BEAM_SCALER_OVERFLOW_EN
        check("rst_ovf", 32'(overflow), 32'd0);
`endif
        step(1'b0, 2'b00, 2'b00);
        check("rel1_trig", 32'(trig), 32'd0);
        check("rel1_cv", 32'(count_valid), 32'd0);
        step(1'b0, 2'b00, 2'b00);
        check("rel2_trig", 32'(trig), 32'd0);
        run_to(100, 2'b00, 2'b00);
        check_strobe("reset", 100, 8'h00);

        apply_vecs(0, 24, "hold");
        run_to(200, 2'b00, 2'b00);
        check_strobe("holdoff", 200, 8'h04);

        pulse_cnt = '{0, 0};
        run_to(300, 2'b10, 2'b00);
        check_strobe("sat", 300, 8'hF0);
        check("sat_pulses1", pulse_cnt[1], 20);
        check("sat_pulses0", pulse_cnt[0], 0);
`ifdef BEAM_SCALER_OVERFLOW_EN
        check("sat_ovf", 32'(overflow), 32'h2);
`endif

        apply_vecs(25, 36, "mask");
        run_to(400, 2'b00, 2'b00);
        check_strobe("mask", 400, 8'h01);
`ifdef BEAM_SCALER_OVERFLOW_EN
        check("mask_ovf", 32'(overflow), 32'h0);
`endif

        run_to(498, 2'b00, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        run_to(500, 2'b00, 2'b00);
        check_strobe("edge99", 500, 8'h01);
        run_to(550, 2'b00, 2'b00);
        check("hold_count", 32'(count), 32'h01);
        check("hold_cv", 32'(count_valid), 32'd0);
        run_to(599, 2'b00, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        check_strobe("edge0_close", 600, 8'h00);
        step(1'b0, 2'b00, 2'b00);
        check("edge0_pulse", 32'(trig), 32'h1);
        run_to(700, 2'b00, 2'b00);
        check_strobe("edge0_next", 700, 8'h01);

        step(1'b0, 2'b01, 2'b00);
        step(1'b0, 2'b01, 2'b00);
        check("pre_rst_pulse", 32'(trig), 32'h1);
        step(1'b1, 2'b01, 2'b00);
        check("mid_rst_trig", 32'(trig), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_cv", 32'(count_valid), 32'd0);
        step(1'b0, 2'b01, 2'b00);
        check("post_rst1_trig", 32'(trig), 32'd0);
        check("post_rst1_cv", 32'(count_valid), 32'd0);
        step(1'b0, 2'b01, 2'b00);
        check("post_rst2_trig", 32'(trig), 32'h1);
        pulse_cnt = '{0, 0};
        run_to(100, 2'b01, 2'b00);
        check_strobe("post_rst", 100, 8'h0F);
        check("post_rst_pulses0", pulse_cnt[0], 19);
`ifdef BEAM_SCALER_OVERFLOW_EN
        check("post_rst_ovf", 32'(overflow), 32'h1);
`endif

        check("trig_any_or", any_bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
